// File: rtl/bnn_serial_tx.sv
// Strobe-qualified two-wire serial transmitter: one word per handshake, MSB first,
// optional even-parity bit, every level held long enough for a 3-flop synchronizer.
module bnn_serial_tx #(
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int PARITY_EN   = 1,
  parameter int GAP_CYCLES  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              ser_data,
  output logic              ser_strobe,
  output logic              busy,
  output logic              done
);
  localparam int NB   = DATA_W + ((PARITY_EN != 0) ? 1 : 0);
  localparam int CMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int BW   = $clog2(NB + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(NB - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, GAP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [NB-1:0]   sh_q, sh_d;
  logic [NB-1:0]   load_word;
  logic            data_d, strobe_d, done_d;

  // Parity rides in the LSB so it naturally goes out last.
  if (PARITY_EN != 0) begin : g_par
    assign load_word = {tx_data, ^tx_data};
  end else begin : g_nopar
    assign load_word = tx_data;
  end

  assign tx_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (tx_valid) begin
          state_d = SETUP;
          bit_d   = '0;
          sh_d    = load_word;
        end
      end
      SETUP: if (cnt_q == HOLD_LAST) begin
        state_d = STROBE;
        cnt_d   = '0;
      end
      STROBE: if (cnt_q == HOLD_LAST) begin
        cnt_d = '0;
        if (bit_q == BIT_LAST) state_d = GAP;
        else begin
          state_d = SETUP;
          bit_d   = bit_q + 1'b1;
          sh_d    = sh_q << 1;
        end
      end
      GAP: if (cnt_q == GAP_LAST) begin
        state_d = IDLE;
        cnt_d   = '0;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Wire levels are computed from the next state so they leave a flop directly.
    data_d   = ((state_d == SETUP) || (state_d == STROBE)) && sh_d[NB-1];
    strobe_d = (state_d == STROBE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      ser_data   <= 1'b0;
      ser_strobe <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      ser_data   <= data_d;
      ser_strobe <= strobe_d;
      done       <= done_d;
    end
  end
endmodule
